seq_pattern_counter: RTL and testbench

SEQ_PATTERN_COUNTER -- requirements
Module: seq_pattern_counter

---
 rtl/seq_pattern_counter_pkg.sv | 8 +
 rtl/seq_pattern_counter_if.sv | 9 +
 rtl/seq_pattern_counter_window.sv | 40 ++++
 rtl/seq_pattern_counter.sv | 83 ++++++++
 tb/tb_seq_pattern_counter.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/seq_pattern_counter_pkg.sv
// Shared types and default sizes for the serial pattern counter.
package seq_cnt_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam int PAT_W_DEF = 4;
  localparam int CNT_W_DEF = 8;
  localparam int LEN_W_DEF = 16;
endpackage

// File: rtl/seq_pattern_counter_if.sv
// Serial bit stream handshake: transfer = in_valid & in_ready.
interface seq_pattern_counter_if;
  logic in_valid;
  logic in_bit;
  logic in_ready;

  modport master (output in_valid, in_bit, input in_ready);
  modport slave  (input in_valid, in_bit, output in_ready);
endinterface

// File: rtl/seq_pattern_counter_window.sv
// Sliding PAT_W-bit window with fill tracking; match looks at the window as it
// would be after shifting in bit_in, so it is valid on the transfer cycle.
module pattern_window
  import seq_cnt_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             clear,
  input  logic [PAT_W-1:0] pattern,
  input  logic             bit_in,
  output logic             match
);
  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);
  localparam logic [FW-1:0] NEED = FW'(PAT_W - 1);

  logic [PAT_W-1:0] window;
  logic [PAT_W-1:0] next_win;
  logic [FW-1:0]    fill;

  assign next_win = {window[PAT_W-2:0], bit_in};
  assign match    = (next_win == pattern) && (fill >= NEED);

  // clear wins over shift so a non-overlapping match discards the whole window
  always_ff @(posedge clk) begin
    if (!rst) begin
      window <= '0;
      fill   <= '0;
    end else if (clear) begin
      window <= '0;
      fill   <= '0;
    end else if (shift_en) begin
      window <= next_win;
      if (fill != FULL) fill <= fill + 1'b1;
    end
  end
endmodule

// File: rtl/seq_pattern_counter.sv
// Frame-based serial pattern counter: FSM, bit/match counters and handshake.
module seq_pattern_counter
  import seq_cnt_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [PAT_W-1:0]      cfg_pattern,
  input  logic                  cfg_overlap,
  input  logic [LEN_W-1:0]      cfg_frame_len,
  seq_pattern_counter_if.slave  s_in,
  output logic [CNT_W-1:0]      count,
  output logic                  match_pulse,
  output logic                  busy,
  output logic                  done
);
  state_e           state, nxt;
  logic [PAT_W-1:0] pat_q;
  logic             ovl_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] bit_cnt, bit_nxt;
  logic             xfer, start_acc, win_match, win_clear;

  assign s_in.in_ready = (state == RUN);
  assign busy          = (state == RUN);
  assign done          = (state == DONE);

  assign xfer      = s_in.in_valid && (state == RUN);
  assign start_acc = start && (state != RUN);
  assign bit_nxt   = bit_cnt + 1'b1;
  assign win_clear = start_acc || (xfer && win_match && !ovl_q);

  pattern_window #(.PAT_W(PAT_W)) u_win (
    .clk      (clk),
    .rst      (rst),
    .shift_en (xfer),
    .clear    (win_clear),
    .pattern  (pat_q),
    .bit_in   (s_in.in_bit),
    .match    (win_match)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: if (start) nxt = (cfg_frame_len == '0) ? DONE : RUN;
      RUN:        if (xfer && (bit_nxt == len_q)) nxt = DONE;
      default:    nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pat_q       <= '0;
      ovl_q       <= 1'b0;
      len_q       <= '0;
      bit_cnt     <= '0;
      count       <= '0;
      match_pulse <= 1'b0;
    end else begin
      match_pulse <= xfer && win_match;
      if (start_acc) begin
        pat_q   <= cfg_pattern;
        ovl_q   <= cfg_overlap;
        len_q   <= cfg_frame_len;
        bit_cnt <= '0;
        count   <= '0;
      end else if (xfer) begin
        bit_cnt <= bit_nxt;
        if (win_match && (count != '1)) count <= count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seq_pattern_counter.sv
// Directed bench: default-size counter plus a PAT_W=2/CNT_W=3 copy for saturation.
module tb_seq_pattern_counter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main instance (defaults)
  logic        a_start, a_ovl;
  logic [3:0]  a_pat;
  logic [15:0] a_len;
  logic [7:0]  a_count;
  logic        a_mp, a_busy, a_done;
  seq_pattern_counter_if a_if ();

  seq_pattern_counter u_dut (
    .clk(clk), .rst(rst), .start(a_start), .cfg_pattern(a_pat),
    .cfg_overlap(a_ovl), .cfg_frame_len(a_len), .s_in(a_if.slave),
    .count(a_count), .match_pulse(a_mp), .busy(a_busy), .done(a_done)
  );

  // saturation instance
  logic        b_start, b_ovl;
  logic [1:0]  b_pat;
  logic [15:0] b_len;
  logic [2:0]  b_count;
  logic        b_mp, b_busy, b_done;
  seq_pattern_counter_if b_if ();

  seq_pattern_counter #(.PAT_W(2), .CNT_W(3), .LEN_W(16)) u_sat (
    .clk(clk), .rst(rst), .start(b_start), .cfg_pattern(b_pat),
    .cfg_overlap(b_ovl), .cfg_frame_len(b_len), .s_in(b_if.slave),
    .count(b_count), .match_pulse(b_mp), .busy(b_busy), .done(b_done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int a_pulses, b_pulses;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic a_go(input logic [3:0] pat, input logic ovl, input logic [15:0] len);
    @(negedge clk);
    a_start = 1'b1; a_pat = pat; a_ovl = ovl; a_len = len;
    @(posedge clk); #1;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  // one transfer, then `gaps` idle cycles; pulse sampled just after the edge
  task automatic a_bit(input logic b, input int gaps);
    @(negedge clk);
    a_if.in_valid = 1'b1; a_if.in_bit = b;
    @(posedge clk); #1;
    if (a_mp) a_pulses++;
    @(negedge clk);
    a_if.in_valid = 1'b0;
    for (int g = 0; g < gaps; g++) begin
      @(posedge clk); #1;
      if (a_mp) a_pulses++;
      @(negedge clk);
    end
  endtask

  task automatic a_stream(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) a_bit(bits[i], 0);
  endtask

  task automatic b_bit(input logic b);
    @(negedge clk);
    b_if.in_valid = 1'b1; b_if.in_bit = b;
    @(posedge clk); #1;
    if (b_mp) b_pulses++;
    @(negedge clk);
    b_if.in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    a_start = 0; a_ovl = 0; a_pat = 0; a_len = 0; a_if.in_valid = 0; a_if.in_bit = 0;
    b_start = 0; b_ovl = 0; b_pat = 0; b_len = 0; b_if.in_valid = 0; b_if.in_bit = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", a_count, 0);
    check("rst_flags", {a_if.in_ready, a_busy, a_done, a_mp}, 4'b0000);
    @(negedge clk); rst = 1'b1;

    // overlapping: 1001001 -> 2 matches
    a_pulses = 0;
    a_go(4'b1001, 1'b1, 16'd7);
    check("run_flags", {a_if.in_ready, a_busy, a_done}, 3'b110);
    a_stream(16'b1001001, 7);
    check("ovl_count", a_count, 2);
    check("ovl_pulses", a_pulses, 2);
    check("ovl_done", {a_done, a_busy, a_if.in_ready}, 3'b100);

    // restart from DONE, non-overlapping: same stream -> 1 match
    a_pulses = 0;
    a_go(4'b1001, 1'b0, 16'd7);
    check("restart_flags", {a_done, a_busy, a_count}, {2'b01, 8'd0});
    a_stream(16'b1001001, 7);
    check("novl_count", a_count, 1);
    check("novl_pulses", a_pulses, 1);
    check("novl_done", a_done, 1);

    // gaps of 3 idle cycles between bits
    a_pulses = 0;
    a_go(4'b1001, 1'b0, 16'd4);
    a_bit(1'b1, 3); a_bit(1'b0, 3); a_bit(1'b0, 3);
    check("gap_not_done", {a_done, a_busy, a_count}, {2'b01, 8'd0});
    @(negedge clk); a_if.in_valid = 1'b1; a_if.in_bit = 1'b1;
    @(posedge clk); #1;
    check("gap_done", {a_done, a_mp, a_count}, {2'b11, 8'd1});
    @(negedge clk); a_if.in_valid = 1'b0;

    // reset mid-run after 5 bits, then a clean frame
    a_go(4'b1001, 1'b1, 16'd10);
    a_stream(16'b11100, 5);
    check("pre_rst_count", a_count, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_flags", {a_done, a_busy, a_if.in_ready, a_mp, a_count}, 12'h000);
    @(negedge clk); rst = 1'b1;
    a_pulses = 0;
    a_go(4'b1001, 1'b0, 16'd4);
    a_bit(1'b1, 0);
    check("no_stale_match", {a_mp, a_count}, 9'h000);
    a_stream(16'b001, 3);
    check("post_rst_count", a_count, 1);
    check("post_rst_done", a_done, 1);

    // frame_len = 0
    a_go(4'b1001, 1'b1, 16'd0);
    check("len0", {a_done, a_busy, a_count}, {2'b10, 8'd0});

    // start during RUN ignored; cfg changes after latch ignored
    a_go(4'b1001, 1'b0, 16'd4);
    a_stream(16'b10, 2);
    @(negedge clk);
    a_start = 1'b1; a_pat = 4'b0000; a_len = 16'd2; a_ovl = 1'b1;
    @(posedge clk); #1;
    check("start_in_run", {a_busy, a_done}, 2'b10);
    @(negedge clk); a_start = 1'b0;
    a_bit(1'b0, 0);
    check("ign_3rd", {a_busy, a_count}, {1'b1, 8'd0});
    a_bit(1'b1, 0);
    check("ign_final", {a_done, a_count}, {1'b1, 8'd1});

    // saturation: ten "10" pairs on a 3-bit counter
    b_pulses = 0;
    @(negedge clk);
    b_start = 1'b1; b_pat = 2'b10; b_ovl = 1'b1; b_len = 16'd20;
    @(posedge clk); #1;
    @(negedge clk); b_start = 1'b0;
    for (int i = 0; i < 10; i++) begin b_bit(1'b1); b_bit(1'b0); end
    check("sat_count", b_count, 7);
    check("sat_pulses", b_pulses, 10);
    check("sat_done", b_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1, "timeout");
  end
endmodule
